// File: rtl/mips_cpu_memory_bus_ws_if.sv
// Wait-state memory bus: request/accept handshake between a CPU master
// and the on-chip word memory slave.
`timescale 1ns/1ps
interface mips_cpu_memory_bus_ws_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BE = DATA_WIDTH / 8;

  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BE-1:0]         byteenable;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  rangeerr;

  modport master (
    output read, write, addr, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid, rangeerr
  );

  modport slave (
    input  read, write, addr, byteenable, writedata,
    output waitrequest, readdata, readdatavalid, rangeerr
  );
endinterface

// File: rtl/mips_cpu_memory_bus_ws.sv
// Byte-lane word memory that stalls every access by WAIT_STATES cycles,
// with registered read data and a sticky out-of-range flag.
`timescale 1ns/1ps
module mips_cpu_memory_bus_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 2
) (
  input logic clk,
  input logic reset,
  mips_cpu_memory_bus_ws_if.slave bus
);

  localparam int BE = DATA_WIDTH / 8;
  localparam int LB = $clog2(BE);
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit HAS_WS = (WAIT_STATES != 0);
  localparam logic [3:0] WS_M1 =
    4'(HAS_WS ? WAIT_STATES - 1 : 0);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic req;
  logic wait_s;
  logic accept;
  logic do_wr;
  logic do_rd;

  logic                  borrow;
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic [IW-1:0]         widx;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] readdata_q;
  logic                  rdv_q;
  logic                  rerr_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: '0};

  assign req = bus.read | bus.write;

  // borrow out of the subtraction means addr is below the base
  assign {borrow, off} = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign idx      = off >> LB;
  assign in_range = ~borrow &
    ({1'b0, idx} < (ADDR_WIDTH+1)'(DEPTH_WORDS));
  assign widx     = idx[IW-1:0];

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BE; i++) begin
      lane_mask[8*i +: 8] = {8{bus.byteenable[i]}};
    end
  end

  assign rd_word = mem[widx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req && HAS_WS) begin
          state_d = STALL;
          cnt_d   = WS_M1;
        end
      end
      STALL: begin
        // a dropped request abandons the stall without touching memory
        if (!req || cnt_q == 4'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wait_s = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE:    wait_s = req && HAS_WS;
        STALL:   wait_s = (cnt_q != 4'd0);
        default: wait_s = 1'b0;
      endcase
    end
  end

  assign accept = req & ~wait_s & ~reset;
  assign do_wr  = accept & bus.write & in_range;
  assign do_rd  = accept & bus.read & ~bus.write;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < BE; i++) begin
        if (bus.byteenable[i]) begin
          mem[widx][8*i +: 8] <= bus.writedata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      rerr_q     <= 1'b0;
    end else begin
      rdv_q <= do_rd;
      if (do_rd) begin
        readdata_q <= in_range ? (rd_word & lane_mask) : '0;
      end
      if (accept && !in_range) begin
        rerr_q <= 1'b1;
      end
    end
  end

  assign bus.waitrequest   = wait_s;
  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rdv_q;
  assign bus.rangeerr      = rerr_q;

endmodule

// File: doc/mips_cpu_memory_bus_ws.md
MIPS_CPU_MEMORY_BUS_WS -- requirements
Module: mips_cpu_memory_bus_ws

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits; SHALL be a multiple of 8 and at least 16; BE = DATA_WIDTH/8 byte lanes.
REQ-002 Parameter ADDR_WIDTH, 32, byte-address width.
REQ-003 Parameter DEPTH_WORDS, 1024, number of DATA_WIDTH words stored; power of two.
REQ-004 Parameter BASE_ADDR, 0, byte address of word 0; aligned to BE.
REQ-005 Parameter WAIT_STATES, 2, stall cycles per access, legal range 0..15.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset; one clock, synchronous reset, active-high.
REQ-008 read  input  1  read request, held until accepted.
REQ-009 write  input  1  write request, held until accepted.
REQ-010 addr  input  ADDR_WIDTH  byte address; low log2(BE) bits ignored.
REQ-011 byteenable  input  BE  lane enables, bit i = bits [8i+7:8i].
REQ-012 writedata  input  DATA_WIDTH  write data.
REQ-013 waitrequest  output  1  high = request not accepted this cycle.
REQ-014 readdata  output  DATA_WIDTH  registered read data.
REQ-015 readdatavalid  output  1  one-cycle pulse qualifying readdata.
REQ-016 rangeerr  output  1  sticky: any accepted access was out of range.

Function
REQ-017 Word index = (addr - BASE_ADDR) >> log2(BE); in range iff addr >= BASE_ADDR and index < DEPTH_WORDS.
REQ-018 FSM states IDLE, STALL; 4-bit counter cnt.
REQ-019 IDLE, (read|write) high, WAIT_STATES>0: waitrequest high combinationally, cnt <= WAIT_STATES-1, go STALL.
REQ-020 STALL: waitrequest = (cnt != 0); cnt decrements each cycle while nonzero; when cnt==0 waitrequest low and access is accepted at that edge, go IDLE.
REQ-021 WAIT_STATES=0: waitrequest held low; request in IDLE accepted same cycle; FSM stays IDLE.
REQ-022 Accepted = (read|write) & ~waitrequest at rising edge; exactly WAIT_STATES cycles with waitrequest high precede every accepted access.
REQ-023 Back-to-back requests: each accepted access returns to IDLE and the next request stalls afresh; no stall credit carried over.
REQ-024 Request dropped while in STALL: go IDLE next edge, no memory access, no readdatavalid.
REQ-025 Accepted write, in range: for each i with byteenable[i]=1, lane i of word written; other lanes unchanged.
REQ-026 Accepted read, in range: next cycle readdata lane i = stored lane i if byteenable[i] else 0; readdatavalid=1 for exactly that cycle.
REQ-027 readdata holds its value until the next accepted read.
REQ-028 read and write both high: treated as write; no readdatavalid.
REQ-029 Out-of-range accepted write: no storage change, rangeerr <= 1.
REQ-030 Out-of-range accepted read: readdata = 0, readdatavalid pulses, rangeerr <= 1.
REQ-031 byteenable = 0 on accepted write: no change; on read: readdata = 0 with readdatavalid.
REQ-032 Storage array initialised to all zeros at time 0.

Reset
REQ-033 reset high at an edge: state IDLE, cnt=0, readdata=0, readdatavalid=0, rangeerr=0.
REQ-034 waitrequest low during reset cycles.
REQ-035 Reset mid-STALL aborts access: no write, no readdatavalid.
REQ-036 Reset does not clear the storage array.

Verification
REQ-037 WAIT_STATES=2: write addr 20, data 0000ffff, be 1111 -> waitrequest high 2 cycles, accepted on 3rd edge; read addr 20 -> readdatavalid one cycle after accept, readdata=0000ffff.
REQ-038 Write addr 24 abcd12ff be 1111, then write be 0011 data 00005555, read be 1111 -> abcd5555; read be 1000 -> ab000000.
REQ-039 WAIT_STATES=0: alternating write/read every cycle to addresses 0..60 step 4 -> waitrequest never high, every read returns the written value one cycle later.
REQ-040 Request dropped after 1 stall cycle, and reset asserted mid-STALL -> subsequent read of that word returns prior value; rangeerr stays 0.
REQ-041 BASE_ADDR=0x1000, DEPTH_WORDS=16: write addr 0x0FFC and 0x1040 -> rangeerr=1, reads return 0; write 0x103C accepted, readback matches.
REQ-042 read and write both high, addr 8, data 12345678 -> no readdatavalid; later read addr 8 -> 12345678.
